kmeans_seq_ctrl: RTL and testbench

- Parametrised next-generation sequencer for the k-means core. It loads K centroids from the regfile, then streams a programmable RAM point range through the classification pipeline.
- Each iteration it drives the divider and convergence-check blocks, then writes converged centroids back to the regfile and raises an interrupt.
- It generalises centroid count, address width and pipeline depths, and adds an iteration limit, abort, address-range error detection and a completion status.

---
 rtl/kmeans_seq_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_kmeans_seq_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_seq_ctrl.sv
// Sequencer for the k-means core: loads centroids, streams a RAM point range through
// classification, runs divide/convergence each iteration, then writes back and interrupts.
module kmeans_seq_ctrl #(
  parameter int K         = 8,
  parameter int LOG2_K    = 3,
  parameter int ADDR_W    = 9,
  parameter int IT_W      = 10,
  parameter int FILL_LAT  = 2,
  parameter int DIV_LAT   = 1,
  parameter int REG_W     = 4,
  parameter int CENT_BASE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [IT_W-1:0]   max_iter,
  output logic [REG_W-1:0]  reg_num,
  output logic              reg_write,
  output logic              irq,
  output logic              busy,
  output logic [1:0]        status,
  output logic [IT_W-1:0]   iter_count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              in_reg_en,
  output logic [K-1:0]      cent_en,
  output logic [LOG2_K-1:0] cent_idx,
  output logic              first_iter,
  output logic              acc_en,
  output logic              acc_clr_n,
  output logic              div_en,
  output logic              cnv_en,
  output logic              cnv_clr_n,
  input  logic              cnv_valid,
  input  logic              cnv_ok
);

  localparam int CNT_W = 8;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_CALC, S_CHECK, S_WAIT, S_WRBACK, S_IRQ
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   first_q, first_d, last_q, last_d, ram_addr_q, ram_addr_d;
  logic [1:0]          status_q, status_d;
  logic [IT_W-1:0]     iter_count_q, iter_count_d;
  logic                first_iter_q, first_iter_d;
  logic [FILL_LAT-1:0] pipe_q, pipe_d;
  logic [REG_W-1:0]    reg_num_q, reg_num_d;
  logic [K-1:0]        cent_en_q, cent_en_d;
  logic [LOG2_K-1:0]   cent_idx_q, cent_idx_d;
  logic reg_write_q, reg_write_d, irq_q, irq_d, busy_q, busy_d;
  logic ram_cs_n_q, ram_cs_n_d, in_reg_en_q, in_reg_en_d, acc_clr_n_q, acc_clr_n_d;
  logic div_en_q, div_en_d, cnv_en_q, cnv_en_d, cnv_clr_n_q, cnv_clr_n_d;
  logic issue_entry;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    last_d       = last_q;
    ram_addr_d   = ram_addr_q;
    status_d     = status_q;
    iter_count_d = iter_count_q;
    first_iter_d = first_iter_q;

    case (state_q)
      S_IDLE: if (go) begin
        status_d     = 2'b00;
        iter_count_d = '0;
        first_iter_d = 1'b1;
        first_d      = first_addr;
        last_d       = last_addr;
        cnt_d        = '0;
        if (last_addr < first_addr) begin
          state_d  = S_IRQ;
          status_d = 2'b11;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: if (cnt_q == CNT_W'(K - 1)) begin
        state_d    = S_ISSUE;
        ram_addr_d = first_q;
      end else cnt_d = cnt_q + CNT_W'(1);
      // Stop on last_q itself so the address never steps past the range or wraps.
      S_ISSUE: if (ram_addr_q == last_q) begin
        state_d = S_DRAIN;
        cnt_d   = '0;
      end else ram_addr_d = ram_addr_q + ADDR_W'(1);
      S_DRAIN: if (cnt_q == CNT_W'(FILL_LAT - 1)) begin
        state_d = S_CALC;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      S_CALC: if (cnt_q == CNT_W'(DIV_LAT - 1)) begin
        state_d = S_CHECK;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      S_CHECK: if (cnt_q == CNT_W'(K - 1)) begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      S_WAIT: if (cnv_valid) begin
        iter_count_d = (iter_count_q == '1) ? iter_count_q : iter_count_q + IT_W'(1);
        cnt_d        = '0;
        if (cnv_ok) begin
          state_d  = S_WRBACK;
          status_d = 2'b00;
        end else if (max_iter != '0 && (iter_count_q + IT_W'(1)) == max_iter) begin
          state_d  = S_WRBACK;
          status_d = 2'b01;
        end else begin
          state_d    = S_ISSUE;
          ram_addr_d = first_q;
        end
      end
      S_WRBACK: if (cnt_q == CNT_W'(K - 1)) state_d = S_IRQ;
                else cnt_d = cnt_q + CNT_W'(1);
      S_IRQ:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort outranks everything else, including a same-cycle convergence result.
    if (abort && state_q != S_IDLE && state_q != S_IRQ) begin
      state_d      = S_IRQ;
      status_d     = 2'b10;
      iter_count_d = iter_count_q;
    end

    issue_entry = (state_d == S_ISSUE) && (state_q != S_ISSUE);
    if (issue_entry) first_iter_d = 1'b0;

    // Outputs are computed from the next state so they are registered yet aligned with it.
    reg_write_d = (state_d == S_WRBACK);
    irq_d       = (state_d == S_IRQ);
    busy_d      = (state_d != S_IDLE);
    ram_cs_n_d  = (state_d != S_ISSUE);
    in_reg_en_d = (state_d == S_ISSUE);
    acc_clr_n_d = !issue_entry;
    div_en_d    = (state_d == S_CALC) || (state_d == S_CHECK);
    cnv_en_d    = (state_d == S_CHECK);
    cnv_clr_n_d = !((state_d == S_CALC) && (cnt_d == '0));
    reg_num_d   = '0;
    cent_en_d   = '0;
    cent_idx_d  = '0;
    if (state_d == S_LOAD || state_d == S_WRBACK)
      reg_num_d = REG_W'(CENT_BASE) + cnt_d[REG_W-1:0];
    if (state_d == S_LOAD || state_d == S_CHECK) begin
      cent_en_d  = K'(1) << cnt_d;
      cent_idx_d = cnt_d[LOG2_K-1:0];
    end

    pipe_d    = pipe_q << 1;
    pipe_d[0] = in_reg_en_q;
    if (state_d == S_IRQ) pipe_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      first_q      <= '0;
      last_q       <= '0;
      ram_addr_q   <= '0;
      status_q     <= 2'b00;
      iter_count_q <= '0;
      first_iter_q <= 1'b1;
      pipe_q       <= '0;
      reg_num_q    <= '0;
      cent_en_q    <= '0;
      cent_idx_q   <= '0;
      reg_write_q  <= 1'b0;
      irq_q        <= 1'b0;
      busy_q       <= 1'b0;
      ram_cs_n_q   <= 1'b1;
      in_reg_en_q  <= 1'b0;
      acc_clr_n_q  <= 1'b1;
      div_en_q     <= 1'b0;
      cnv_en_q     <= 1'b0;
      cnv_clr_n_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      last_q       <= last_d;
      ram_addr_q   <= ram_addr_d;
      status_q     <= status_d;
      iter_count_q <= iter_count_d;
      first_iter_q <= first_iter_d;
      pipe_q       <= pipe_d;
      reg_num_q    <= reg_num_d;
      cent_en_q    <= cent_en_d;
      cent_idx_q   <= cent_idx_d;
      reg_write_q  <= reg_write_d;
      irq_q        <= irq_d;
      busy_q       <= busy_d;
      ram_cs_n_q   <= ram_cs_n_d;
      in_reg_en_q  <= in_reg_en_d;
      acc_clr_n_q  <= acc_clr_n_d;
      div_en_q     <= div_en_d;
      cnv_en_q     <= cnv_en_d;
      cnv_clr_n_q  <= cnv_clr_n_d;
    end
  end

  assign reg_num    = reg_num_q;
  assign reg_write  = reg_write_q;
  assign irq        = irq_q;
  assign busy       = busy_q;
  assign status     = status_q;
  assign iter_count = iter_count_q;
  assign ram_addr   = ram_addr_q;
  assign ram_cs_n   = ram_cs_n_q;
  assign ram_oe_n   = ram_cs_n_q;
  assign ram_we_n   = 1'b1;
  assign in_reg_en  = in_reg_en_q;
  assign cent_en    = cent_en_q;
  assign cent_idx   = cent_idx_q;
  assign first_iter = first_iter_q;
  assign acc_en     = pipe_q[FILL_LAT-1];
  assign acc_clr_n  = acc_clr_n_q;
  assign div_en     = div_en_q;
  assign cnv_en     = cnv_en_q;
  assign cnv_clr_n  = cnv_clr_n_q;

endmodule

// File: tb/tb_kmeans_seq_ctrl.sv
// Directed bench for kmeans_seq_ctrl: each run logs outputs per cycle after the go edge,
// then compares the logs against hand-computed cycle positions.
module tb_kmeans_seq_ctrl;
  localparam int K = 8, LOG2_K = 3, ADDR_W = 9, IT_W = 10;
  localparam int FILL_LAT = 2, DIV_LAT = 1, REG_W = 4, CENT_BASE = 2;
  localparam int LOG_N = 100;

  logic clk = 1'b0;
  logic rst_n, go, abort, cnv_valid, cnv_ok;
  logic [ADDR_W-1:0] first_addr, last_addr, ram_addr;
  logic [IT_W-1:0]   max_iter, iter_count;
  logic [REG_W-1:0]  reg_num;
  logic [1:0]        status;
  logic [K-1:0]      cent_en;
  logic [LOG2_K-1:0] cent_idx;
  logic reg_write, irq, busy, ram_cs_n, ram_oe_n, ram_we_n, in_reg_en;
  logic first_iter, acc_en, acc_clr_n, div_en, cnv_en, cnv_clr_n;

  int num_checks = 0;
  int num_errors = 0;

  int lg_reg_num[LOG_N], lg_reg_write[LOG_N], lg_irq[LOG_N], lg_busy[LOG_N];
  int lg_ram_addr[LOG_N], lg_cs_n[LOG_N], lg_in_reg_en[LOG_N], lg_cent_en[LOG_N];
  int lg_cent_idx[LOG_N], lg_first_iter[LOG_N], lg_acc_en[LOG_N], lg_acc_clr_n[LOG_N];
  int lg_div_en[LOG_N], lg_cnv_en[LOG_N], lg_cnv_clr_n[LOG_N], lg_status[LOG_N];
  int lg_iter[LOG_N];

  always #5 clk = ~clk;

  kmeans_seq_ctrl #(
    .K(K), .LOG2_K(LOG2_K), .ADDR_W(ADDR_W), .IT_W(IT_W), .FILL_LAT(FILL_LAT),
    .DIV_LAT(DIV_LAT), .REG_W(REG_W), .CENT_BASE(CENT_BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr), .max_iter(max_iter),
    .reg_num(reg_num), .reg_write(reg_write), .irq(irq), .busy(busy),
    .status(status), .iter_count(iter_count), .ram_addr(ram_addr),
    .ram_cs_n(ram_cs_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .in_reg_en(in_reg_en), .cent_en(cent_en), .cent_idx(cent_idx),
    .first_iter(first_iter), .acc_en(acc_en), .acc_clr_n(acc_clr_n),
    .div_en(div_en), .cnv_en(cnv_en), .cnv_clr_n(cnv_clr_n),
    .cnv_valid(cnv_valid), .cnv_ok(cnv_ok)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int c);
    lg_reg_num[c]    = int'(reg_num);
    lg_reg_write[c]  = int'(reg_write);
    lg_irq[c]        = int'(irq);
    lg_busy[c]       = int'(busy);
    lg_ram_addr[c]   = int'(ram_addr);
    lg_cs_n[c]       = int'(ram_cs_n & ram_oe_n);
    lg_in_reg_en[c]  = int'(in_reg_en);
    lg_cent_en[c]    = int'(cent_en);
    lg_cent_idx[c]   = int'(cent_idx);
    lg_first_iter[c] = int'(first_iter);
    lg_acc_en[c]     = int'(acc_en);
    lg_acc_clr_n[c]  = int'(acc_clr_n);
    lg_div_en[c]     = int'(div_en);
    lg_cnv_en[c]     = int'(cnv_en);
    lg_cnv_clr_n[c]  = int'(cnv_clr_n);
    lg_status[c]     = int'(status);
    lg_iter[c]       = int'(iter_count);
  endtask

  // Cycle 0 is the first cycle after the edge that samples go.
  task automatic applyStimulus(input int n, input int abort_at, input int reset_at,
                               input int go_until);
    go = 1'b1;
    tick();
    for (int c = 0; c < n; c++) begin
      sample(c);
      go    = (c < go_until);
      abort = (c == abort_at);
      rst_n = (c != reset_at);
      tick();
    end
    go    = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
  endtask

  function automatic int countHigh(input int which, input int n);
    int total = 0;
    for (int c = 0; c < n; c++) begin
      case (which)
        0: total += lg_acc_en[c];
        1: total += lg_irq[c];
        2: total += lg_reg_write[c];
        3: total += (lg_cs_n[c] == 0) ? 1 : 0;
        default: total += (lg_acc_clr_n[c] == 0) ? 1 : 0;
      endcase
    end
    return total;
  endfunction

  initial begin
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; cnv_valid = 1'b0; cnv_ok = 1'b0;
    first_addr = '0; last_addr = '0; max_iter = '0;
    tick();
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cs_n", ram_cs_n, 1);
    checkOutput("rst_oe_n", ram_oe_n, 1);
    checkOutput("rst_we_n", ram_we_n, 1);
    checkOutput("rst_acc_clr_n", acc_clr_n, 1);
    checkOutput("rst_cnv_clr_n", cnv_clr_n, 1);
    checkOutput("rst_first_iter", first_iter, 1);
    checkOutput("rst_status", status, 0);
    checkOutput("rst_iter", iter_count, 0);
    checkOutput("rst_cent_en", cent_en, 0);
    rst_n = 1'b1;
    tick();

    // Converge on the first WAIT.
    first_addr = 9'd0; last_addr = 9'd3; max_iter = '0; cnv_valid = 1'b1; cnv_ok = 1'b1;
    applyStimulus(40, -1, -1, 0);
    for (int k = 0; k < K; k++) begin
      checkOutput("load_reg_num", lg_reg_num[k], 2 + k);
      checkOutput("load_cent_en", lg_cent_en[k], 1 << k);
      checkOutput("load_cent_idx", lg_cent_idx[k], k);
    end
    checkOutput("first_iter_load", lg_first_iter[7], 1);
    checkOutput("first_iter_issue", lg_first_iter[8], 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("issue_addr", lg_ram_addr[8 + i], i);
      checkOutput("issue_cs_n", lg_cs_n[8 + i], 0);
      checkOutput("issue_in_reg_en", lg_in_reg_en[8 + i], 1);
    end
    checkOutput("drain_cs_n", lg_cs_n[12], 1);
    checkOutput("acc_clr_first", lg_acc_clr_n[8], 0);
    checkOutput("acc_clr_second", lg_acc_clr_n[9], 1);
    checkOutput("acc_en_count", countHigh(0, 40), 4);
    checkOutput("acc_en_early", lg_acc_en[9], 0);
    checkOutput("acc_en_start", lg_acc_en[10], 1);
    checkOutput("acc_en_end", lg_acc_en[13], 1);
    checkOutput("calc_div_en", lg_div_en[14], 1);
    checkOutput("calc_cnv_clr_n", lg_cnv_clr_n[14], 0);
    checkOutput("check_cnv_en", lg_cnv_en[15], 1);
    checkOutput("check_cent_last", lg_cent_en[22], 128);
    checkOutput("wait_cnv_en", lg_cnv_en[23], 0);
    for (int k = 0; k < K; k++) begin
      checkOutput("wb_write", lg_reg_write[24 + k], 1);
      checkOutput("wb_reg_num", lg_reg_num[24 + k], 2 + k);
    end
    checkOutput("wb_count", countHigh(2, 40), 8);
    checkOutput("conv_irq_pos", lg_irq[32], 1);
    checkOutput("conv_irq_count", countHigh(1, 40), 1);
    checkOutput("conv_idle", lg_busy[33], 0);
    checkOutput("conv_status", status, 0);
    checkOutput("conv_iter", iter_count, 1);

    // Iteration limit of 3 with no convergence.
    max_iter = 10'd3; cnv_ok = 1'b0;
    applyStimulus(80, -1, -1, 0);
    checkOutput("maxit_passes", countHigh(4, 80), 3);
    checkOutput("maxit_issue_cycles", countHigh(3, 80), 12);
    checkOutput("maxit_wb_count", countHigh(2, 80), 8);
    checkOutput("maxit_irq_pos", lg_irq[64], 1);
    checkOutput("maxit_irq_count", countHigh(1, 80), 1);
    checkOutput("maxit_status", status, 1);
    checkOutput("maxit_iter", iter_count, 3);

    // Inverted range.
    first_addr = 9'd5; last_addr = 9'd4; max_iter = '0;
    applyStimulus(5, -1, -1, 0);
    checkOutput("range_irq_pos", lg_irq[0], 1);
    checkOutput("range_irq_count", countHigh(1, 5), 1);
    checkOutput("range_no_ram", countHigh(3, 5), 0);
    checkOutput("range_idle", lg_busy[1], 0);
    checkOutput("range_status", status, 3);
    checkOutput("range_iter", iter_count, 0);

    // Abort in the third ISSUE cycle.
    first_addr = 9'd0; last_addr = 9'd3; cnv_valid = 1'b1; cnv_ok = 1'b1;
    applyStimulus(40, 10, -1, 0);
    checkOutput("abort_cs_before", lg_cs_n[10], 0);
    checkOutput("abort_cs_after", lg_cs_n[11], 1);
    checkOutput("abort_in_reg_en", lg_in_reg_en[11], 0);
    checkOutput("abort_acc_before", lg_acc_en[10], 1);
    checkOutput("abort_acc_after", lg_acc_en[11], 0);
    checkOutput("abort_irq_pos", lg_irq[11], 1);
    checkOutput("abort_irq_count", countHigh(1, 40), 1);
    checkOutput("abort_no_wb", countHigh(2, 40), 0);
    checkOutput("abort_idle", lg_busy[12], 0);
    checkOutput("abort_status", status, 2);

    // Single-point range.
    first_addr = 9'd7; last_addr = 9'd7;
    applyStimulus(40, -1, -1, 0);
    checkOutput("single_issue_cycles", countHigh(3, 40), 1);
    checkOutput("single_addr", lg_ram_addr[8], 7);
    checkOutput("single_acc_count", countHigh(0, 40), 1);
    checkOutput("single_acc_pos", lg_acc_en[10], 1);
    checkOutput("single_irq_pos", lg_irq[29], 1);
    checkOutput("single_status", status, 0);

    // go held high while busy, then a one-cycle reset in the middle of CHECK.
    first_addr = 9'd0; last_addr = 9'd3; cnv_valid = 1'b0;
    applyStimulus(30, -1, 17, 18);
    checkOutput("gohold_reg_num", lg_reg_num[3], 5);
    checkOutput("gohold_addr", lg_ram_addr[11], 3);
    checkOutput("gohold_check_cent", lg_cent_en[17], 4);
    checkOutput("gohold_check_cnv_en", lg_cnv_en[17], 1);
    checkOutput("midrst_busy", lg_busy[18], 0);
    checkOutput("midrst_cs_n", lg_cs_n[18], 1);
    checkOutput("midrst_cnv_en", lg_cnv_en[18], 0);
    checkOutput("midrst_div_en", lg_div_en[18], 0);
    checkOutput("midrst_cent_en", lg_cent_en[18], 0);
    checkOutput("midrst_first_iter", lg_first_iter[18], 1);
    checkOutput("midrst_acc_clr_n", lg_acc_clr_n[18], 1);
    checkOutput("midrst_cnv_clr_n", lg_cnv_clr_n[18], 1);
    checkOutput("midrst_ram_addr", lg_ram_addr[18], 0);
    checkOutput("midrst_reg_num", lg_reg_num[18], 0);
    checkOutput("midrst_iter", lg_iter[18], 0);
    checkOutput("midrst_no_irq", countHigh(1, 30), 0);
    checkOutput("midrst_stays_idle", lg_busy[29], 0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end
endmodule
